// File: rtl/signed_int_approx_mul_pkg.sv
// Shared widths and types for the signed approximate 8x8 multiplier.
package signed_int_approx_mul_pkg;

    localparam int W      = 8;
    localparam int MASK_W = 6;
    localparam int RW     = 2 * W;

    typedef logic signed [W-1:0]  operand_t;
    typedef logic        [W:0]    mag_t;
    typedef logic signed [RW-1:0] result_t;
    typedef logic        [MASK_W-1:0] mask_t;

endpackage

// File: rtl/signed_int_approx_mul_if.sv
// Operand/result bundle for signed_int_approx_mul.
// APPROX_EXACT_FLAG_EN adds the exact_flag result signal.
interface signed_int_approx_mul_if;
    import signed_int_approx_mul_pkg::*;

    logic     in_valid;
    operand_t A;
    operand_t B;
    mask_t    Conf_Bit_Mask;
    logic     out_valid;
    result_t  R;
`ifdef APPROX_EXACT_FLAG_EN
    logic     exact_flag;

    modport master (output in_valid, A, B, Conf_Bit_Mask,
                    input  out_valid, R, exact_flag);
    modport slave  (input  in_valid, A, B, Conf_Bit_Mask,
                    output out_valid, R, exact_flag);
`else
    modport master (output in_valid, A, B, Conf_Bit_Mask,
                    input  out_valid, R);
    modport slave  (input  in_valid, A, B, Conf_Bit_Mask,
                    output out_valid, R);
`endif

endinterface

// File: rtl/signed_int_approx_mul_approx_umul8.sv
// Combinational unsigned magnitude multiplier. Walks the product columns
// from LSB upward; a masked low column collapses to OR of its bits and
// stops its carry, which shortens the carry chain.
module approx_umul8
    import signed_int_approx_mul_pkg::*;
(
    input  mag_t              a,
    input  mag_t              b,
    input  mask_t             mask,
    output logic [RW-1:0]     p
);

    logic [RW-1:0] col_mask;

    assign col_mask = {{(RW-MASK_W){1'b0}}, mask};

    // Column walk: sum partial products plus incoming carry per column.
    always_comb begin
        logic [4:0] s;
        logic [4:0] cin;
        cin = '0;
        s   = '0;
        p   = '0;
        for (int c = 0; c < RW; c++) begin
            s = cin;
            for (int i = 0; i <= W; i++) begin
                for (int j = 0; j <= W; j++) begin
                    if (i + j == c) begin
                        s = s + 5'(a[i] & b[j]);
                    end
                end
            end
            if (col_mask[c]) begin
                p[c] = (s != 5'd0);
                cin  = '0;
            end else begin
                p[c] = s[0];
                cin  = {1'b0, s[4:1]};
            end
        end
    end

endmodule

// File: rtl/signed_int_approx_mul.sv
// Signed approximate 8x8 multiplier with one registered stage.
// Sign-magnitude around approx_umul8; optional APPROX_EXACT_FLAG_EN adds
// exact_flag, set when the approximate result equals the true product.
module signed_int_approx_mul
    import signed_int_approx_mul_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    signed_int_approx_mul_if.slave bus
);

    function automatic mag_t to_mag(operand_t v);
        mag_t ext;
        ext = {v[W-1], v};
        return v[W-1] ? -ext : ext;
    endfunction

    function automatic result_t apply_sign(logic neg, logic [RW-1:0] m);
        result_t sm;
        sm = signed'(m);
        return neg ? -sm : sm;
    endfunction

    mag_t          mag_a;
    mag_t          mag_b;
    logic [RW-1:0] prod_mag;
    result_t       r_next;
    result_t       r_p1;
    logic          vld_p1;

    assign mag_a  = to_mag(bus.A);
    assign mag_b  = to_mag(bus.B);
    assign r_next = apply_sign(bus.A[W-1] ^ bus.B[W-1], prod_mag);

    approx_umul8 u_umul (
        .a    (mag_a),
        .b    (mag_b),
        .mask (bus.Conf_Bit_Mask),
        .p    (prod_mag)
    );

    // Stage p1: capture result on accepted operands, valid follows input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            r_p1   <= '0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_p1 <= r_next;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.R         = r_p1;

`ifdef APPROX_EXACT_FLAG_EN
    result_t exact_prod;
    logic    flag_p1;

    assign exact_prod = result_t'(bus.A) * result_t'(bus.B);

    // Stage p1: exactness flag registered alongside the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_p1 <= 1'b0;
        end else if (bus.in_valid) begin
            flag_p1 <= (r_next == exact_prod);
        end
    end

    assign bus.exact_flag = flag_p1;
`endif

endmodule

// File: tb/tb_signed_int_approx_mul.sv
// Self-checking bench for signed_int_approx_mul: directed vectors with
// literal expectations plus an every-cycle comparison against a
// column-walk reference model.
module tb_signed_int_approx_mul;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    bit   checking;

    int   exp_r;
    int   exp_v;
    int   exp_exact;
    int   exp_f;

    signed_int_approx_mul_if bus();

    signed_int_approx_mul dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sign-magnitude with the column rules on plain integers.
    function automatic int model(int a, int b, int m);
        int ma, mb, cin, s, mag, cnt;
        ma  = (a < 0) ? -a : a;
        mb  = (b < 0) ? -b : b;
        cin = 0;
        mag = 0;
        for (int c = 0; c < 16; c++) begin
            cnt = 0;
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    if (i + j == c && ((ma >> i) & 1) == 1 && ((mb >> j) & 1) == 1)
                        cnt++;
            s = cnt + cin;
            if (c < 6 && ((m >> c) & 1) == 1) begin
                if (s != 0) mag += (1 << c);
                cin = 0;
            end else begin
                mag += (s % 2) << c;
                cin = s / 2;
            end
        end
        return ((a < 0) != (b < 0)) ? -mag : mag;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One accepted transaction, then idle; checks the literal result.
    task automatic tx(int a, int b, int m, int req, string name);
        bus.A             = 8'(a);
        bus.B             = 8'(b);
        bus.Conf_Bit_Mask = 6'(m);
        bus.in_valid      = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check(name, int'(bus.R), req);
        check({name, "_vld"}, int'(bus.out_valid), 1);
    endtask

    // Expected registered outputs, advanced on every rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_r    = 0;
            exp_v    = 0;
            exp_f    = 0;
            checking = 1'b1;
        end else begin
            exp_v = int'(bus.in_valid);
            if (bus.in_valid) begin
                exp_r     = model(int'(bus.A), int'(bus.B), int'(bus.Conf_Bit_Mask));
                exp_exact = int'(bus.A) * int'(bus.B);
                exp_f     = (exp_r == exp_exact) ? 1 : 0;
            end
        end
    end

    // Every-cycle compare on the falling edge.
    always @(negedge clk) begin
        if (checking) begin
            check("stream_vld", int'(bus.out_valid), exp_v);
            check("stream_r", int'(bus.R), exp_r);
`ifdef APPROX_EXACT_FLAG_EN
            check("stream_flag", int'(bus.exact_flag), exp_f);
`endif
            if (bus.out_valid === 1'b1 && rst_n === 1'b1) begin
                check("bound", (iabs(int'(bus.R)) <= iabs(exp_exact)) ? 1 : 0, 1);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int held;
        n_cmp    = 0;
        n_bad    = 0;
        checking = 1'b0;
        exp_exact = 0;

        // Pin the reference model with hand-computed values.
        check("model_3x3_m3", model(3, 3, 3), 7);
        check("model_n3x3_m3", model(-3, 3, 3), -7);
        check("model_4x4_m3", model(4, 4, 3), 16);
        check("model_n128sq", model(-128, -128, 0), 16384);
        check("model_n128x127", model(-128, 127, 0), -16256);
        check("model_127sq_m63_lt", (iabs(model(127, 127, 63)) < 16129) ? 1 : 0, 1);

        // Reset held for two edges with valid operands present.
        rst_n             = 1'b0;
        bus.in_valid      = 1'b1;
        bus.A             = 8'sd5;
        bus.B             = 8'sd5;
        bus.Conf_Bit_Mask = 6'd0;
        step();
        step();
        check("reset_r", int'(bus.R), 0);
        check("reset_vld", int'(bus.out_valid), 0);
        rst_n = 1'b1;
        step();
        check("post_reset_r", int'(bus.R), 25);
        check("post_reset_vld", int'(bus.out_valid), 1);
        bus.in_valid = 1'b0;
        step();

        // Exact mode.
        tx(-128, -128, 0, 16384, "exact_n128sq");
        tx(-128, 127, 0, -16256, "exact_n128x127");
        tx(0, -77, 0, 0, "exact_zero");
        tx(-13, 11, 0, -143, "exact_n13x11");

        // Low columns approximated.
        tx(3, 3, 3, 7, "m3_3x3");
        tx(-3, 3, 3, -7, "m3_n3x3");
        tx(4, 4, 3, 16, "m3_4x4");
        tx(127, 127, 63, model(127, 127, 63), "m63_127sq");

        // Hold: idle cycles leave R alone.
        held = int'(bus.R);
        step();
        check("hold_r", int'(bus.R), held);
        check("hold_vld", int'(bus.out_valid), 0);
        step();
        check("hold_r2", int'(bus.R), held);

        // Mask change mid-stream applies to the next accepted operands.
        bus.A             = 8'sd3;
        bus.B             = 8'sd3;
        bus.Conf_Bit_Mask = 6'd0;
        bus.in_valid      = 1'b1;
        step();
        check("midmask_exact", int'(bus.R), 9);
        bus.Conf_Bit_Mask = 6'b000011;
        step();
        check("midmask_approx", int'(bus.R), 7);
        bus.in_valid = 1'b0;
        step();

`ifdef APPROX_EXACT_FLAG_EN
        tx(-57, 93, 0, -5301, "flag_exact_prod");
        check("flag_mask0", int'(bus.exact_flag), 1);
        tx(3, 3, 3, 7, "flag_approx_prod");
        check("flag_mask3", int'(bus.exact_flag), 0);
`endif

        // Streaming sweeps against the model.
        bus.in_valid      = 1'b1;
        bus.Conf_Bit_Mask = 6'b111111;
        for (int a = -128; a <= 126; a++) begin
            for (int b = -128; b <= 126; b += 5) begin
                bus.A = 8'(a);
                bus.B = 8'(b);
                step();
            end
        end
        bus.Conf_Bit_Mask = 6'b010101;
        for (int a = -128; a <= 126; a += 3) begin
            for (int b = -128; b <= 126; b += 5) begin
                bus.A = 8'(a);
                bus.B = 8'(b);
                step();
            end
        end
        bus.in_valid = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_int_approx_mul.md
Name: signed_int_approx_mul

Overview:
- Configurable approximate ("Approx-T") signed 8x8 integer multiplier; 16-bit signed result, one-cycle registered latency.
- A 6-bit configuration mask selects which low-order product columns are approximated, trading accuracy for carry-chain length.
- Sits in the arithmetic datapath; exhaustive error-characterisation benches sweep A and B over -128..126 per mask setting.

Parameters:
- W, 8, operand width (result width 2*W); only 8 is required to be supported.
- MASK_W, 6, width of Conf_Bit_Mask; number of approximable low columns.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid this cycle.
- A  in  8  signed multiplicand (two's complement).
- B  in  8  signed multiplier (two's complement).
- Conf_Bit_Mask  in  6  bit c=1 approximates product column c.
- out_valid  out  1  R holds the result of the operands sampled on the previous edge.
- R  out  16  signed approximate product.

Behaviour:
- Reset: on a rising clk with rst_n=0, R=0 and out_valid=0. Reset overrides in_valid in the same cycle, and any in-flight result is discarded.
- Latency 1: on each edge with rst_n=1:
  - out_valid <= in_valid.
  - When in_valid=1, R <= f(A,B,Conf_Bit_Mask).
  - When in_valid=0, R holds its value.
  - No backpressure.
- f, sign-magnitude:
  - sA=A[7], sB=B[7]. |A| and |B| are 8-bit unsigned; -128 maps to 128 (no saturation).
  - Partial products pp[i][j]=|A|[i]&|B|[j] land in column c=i+j (0..14).
  - Column walk c=0..15, carry accumulator cin (0 at c=0):
    - s = popcount(column c) + cin.
    - If c<6 and Conf_Bit_Mask[c]=1: M[c]=(s!=0) (OR-compression) and cout=0.
    - Otherwise M[c]=s mod 2 and cout=s>>1 (exact).
    - cin for column c+1 = cout.
  - R = (sA^sB) ? -M : M, two's complement in 16 bits; M=0 gives R=0.
- Properties:
  - Conf_Bit_Mask=0 yields the exact product.
  - Approximated |R| is never greater than the exact |A*B|.
  - Max magnitude 16384 (-128*-128) fits in 16-bit signed.
- Mask is sampled with the operands. A mask change between transactions takes effect on the next accepted operand; there is no other state.

Optional Feature:
- Macro APPROX_EXACT_FLAG_EN.
- Defined: adds output port exact_flag (1 bit), registered alongside R.
  - Set to 1 when the approximate result equals the exact product A*B for the sampled operands; reset value 0.
  - Holds when in_valid=0.
- Undefined: port and exact-product logic absent; behaviour otherwise identical.

Decomposition:
- Package signed_int_approx_mul_pkg: W=8, MASK_W=6, RW=16, typedefs for operand, magnitude (9-bit), result and mask.
- One sub-module, approx_umul8: combinational unsigned 8x8 magnitude multiplier implementing the column walk with the mask.
- Top level: sign extraction, magnitude conversion, negation, output registers, optional flag.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, A=5, B=5 -> R=0, out_valid=0; release -> next edge R=25, out_valid=1.
- Exact mode, mask=6'b000000:
  - A=-128, B=-128 -> R=16384.
  - A=-128, B=127 -> R=-16256.
  - A=0, B=-77 -> R=0.
- Mask=6'b000011, A=3, B=3 -> R=7 (col1 OR-compressed, carry dropped).
  - A=-3, B=3 -> R=-7.
  - A=4, B=4 -> R=16 (exact, no populated masked column).
- Mask=6'b111111, A=127, B=127 -> R equals the column-walk model, with |R| < 16129; sweep A, B over -128..126 against the model, zero mismatches.
- Hold: in_valid=0 after a result -> R unchanged and out_valid=0; mask change mid-stream applies only to the next accepted operands.
- With APPROX_EXACT_FLAG_EN:
  - mask=0, any operands -> exact_flag=1.
  - mask=6'b000011, A=3, B=3 -> exact_flag=0.
